// File: rtl/axi4s_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_rr_arbiter_if
// Brief    : Stream bundle between NUM_SRC upstream masters, the arbiter and
//            the downstream slave.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4s_rr_arbiter_if #(
  parameter int DATA_WIDTH = 48,
  parameter int NUM_SRC    = 4
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]            s_valid_i;
  logic [NUM_SRC-1:0]            s_ready_o;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_data_i;
  logic [NUM_SRC-1:0]            s_last_i;
  logic                          m_valid_o;
  logic                          m_ready_i;
  logic [DATA_WIDTH-1:0]         m_data_o;
  logic                          m_last_o;
  logic [SRC_W-1:0]              m_src_o;

  // Arbiter side
  modport slave (
    input  s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o, m_src_o
  );

  // Environment side: sources and downstream sink
  modport master (
    output s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o, m_src_o
  );
endinterface
`default_nettype wire

// File: rtl/axi4s_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4s_rr_arbiter
// Brief    : Packet-locked round-robin arbiter muxing NUM_SRC AXI4-Stream
//            sources onto one registered output stage tagged with source id.
// Revision : 1.0 - initial release
// ============================================================================
module axi4s_rr_arbiter #(
  parameter int DATA_WIDTH = 48,
  parameter int NUM_SRC    = 4
) (
  input  wire                  axi4s_sclk_i,
  input  wire                  axi4s_rstn_i,
  axi4s_rr_arbiter_if.slave    bus
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [SRC_W-1:0] c_last_src = SRC_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SRC_W-1:0]      r_grant;
  logic [SRC_W-1:0]      r_rr_ptr;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic [SRC_W-1:0]      r_m_src;

  logic                  w_any_valid;
  logic [SRC_W-1:0]      w_winner;
  int                    w_idx;
  logic                  w_out_ready;
  logic                  w_src_hs;
  logic                  w_src_last;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic [SRC_W-1:0]      w_ptr_nxt;

  // First valid source at or above rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    w_any_valid = 1'b0;
    w_winner    = '0;
    w_idx       = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
      if (!w_any_valid && bus.s_valid_i[w_idx]) begin
        w_any_valid = 1'b1;
        w_winner    = SRC_W'(w_idx);
      end
    end
  end

  assign w_out_ready = ~r_m_valid | bus.m_ready_i;
  assign w_src_hs    = (r_state == ST_LOCK) & bus.s_valid_i[r_grant] & w_out_ready;
  assign w_src_last  = bus.s_last_i[r_grant];
  assign w_src_data  = bus.s_data_i[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_ptr_nxt   = (r_grant == c_last_src) ? '0 : r_grant + 1'b1;

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_ready
      assign bus.s_ready_o[k] = (r_state == ST_LOCK) && (r_grant == SRC_W'(k)) && w_out_ready;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_valid) w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_src_hs && w_src_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi4s_sclk_i or negedge axi4s_rstn_i) begin
    if (!axi4s_rstn_i) r_state <= ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_ff @(posedge axi4s_sclk_i or negedge axi4s_rstn_i) begin
    if (!axi4s_rstn_i) begin
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_src   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_valid) r_grant <= w_winner;
      if (w_src_hs && w_src_last) r_rr_ptr <= w_ptr_nxt;
      // A new beat may replace the old one in the same cycle it drains
      if (w_src_hs) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_src_data;
        r_m_last  <= w_src_last;
        r_m_src   <= r_grant;
      end else if (r_m_valid && bus.m_ready_i) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign bus.m_valid_o = r_m_valid;
  assign bus.m_data_o  = r_m_data;
  assign bus.m_last_o  = r_m_last;
  assign bus.m_src_o   = r_m_src;

endmodule
`default_nettype wire
